// File: rtl/dff_bank_arbiter_pkg.sv
// Shared sizing defaults for the arbitrated register bank.
package dff_bank_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Address width for a bank of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Width of the last-winner pointer for a given requester count.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_en_reg.sv
// One bank entry: enable-gated register with synchronous active-high reset.
module dff_en_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over enable; otherwise load only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting one writer per cycle into a bank of registers.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] waddr,
  input  logic [N_REQ*WIDTH-1:0]  wdata,
  output logic [N_REQ-1:0]        gnt,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [WIDTH-1:0]        rdata,
  output logic [7:0]              wr_count
);

  localparam int IDX_W = idx_w(N_REQ);

  logic [IDX_W-1:0]  last_winner;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic [N_REQ-1:0]  elig;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_data;
  logic [DEPTH-1:0]  bank_en;
  logic [WIDTH-1:0]  bank_q [DEPTH];

  // A requester being granted this cycle is still holding req; it must not win again.
  assign elig = req & ~gnt;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_winner) + off) % N_REQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign win_addr = waddr[winner*ADDR_W +: ADDR_W];
  assign win_data = wdata[winner*WIDTH +: WIDTH];

  // Out-of-range addresses match no entry, so the grant happens without a write.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_bank
      assign bank_en[g] = found && (win_addr == ADDR_W'(g));

      dff_en_reg #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (bank_en[g]),
        .d   (win_data),
        .q   (bank_q[g])
      );
    end
  endgenerate

  // Combinational read; unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      rdata = bank_q[raddr];
    end
  end

  // Grant pulse, arbitration pointer and accepted-write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      wr_count    <= '0;
      last_winner <= IDX_W'(N_REQ - 1);
    end else if (found) begin
      gnt         <= N_REQ'(1) << winner;
      last_winner <= winner;
      wr_count    <= wr_count + 8'd1;
    end else begin
      gnt         <= '0;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed testbench for dff_bank_arbiter with default parameters.
module tb_dff_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] waddr;
  logic [31:0] wdata;
  logic [3:0] gnt;
  logic [1:0] raddr;
  logic [7:0] rdata;
  logic [7:0] wr_count;

  int checks   = 0;
  int failures = 0;

  dff_bank_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .waddr    (waddr),
    .wdata    (wdata),
    .gnt      (gnt),
    .raddr    (raddr),
    .rdata    (rdata),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1ns after it, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    waddr = 8'b11_10_01_00;
    wdata = 32'h44_33_22_11;
    step();
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000);
    end
    checks++;
    if (wr_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_wr_count got=%0d exp=0", wr_count);
    end
    for (int a = 0; a < 4; a++) begin
      raddr = 2'(a);
      #1;
      checks++;
      if (rdata !== 8'h00) begin
        failures++;
        $display("FAIL reset_rdata addr=%0d got=%h exp=00", a, rdata);
      end
    end
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    apply_reset();
    waddr[5:4]  = 2'd1;
    wdata[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    req = '0;
    raddr = 2'd1;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100);
    end
    checks++;
    if (rdata !== 8'hA5) begin
      failures++;
      $display("FAIL single_rdata got=%h exp=a5", rdata);
    end
    checks++;
    if (wr_count !== 8'd1) begin
      failures++;
      $display("FAIL single_wr_count got=%0d exp=1", wr_count);
    end
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_gnt_pulse got=%b exp=0000", gnt);
    end
  endtask

  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    apply_reset();
    waddr = 8'b11_10_01_00;
    wdata = 32'hC3_C2_C1_C0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      exp = 4'b0001 << order[k];
      checks++;
      if (gnt !== exp) begin
        failures++;
        $display("FAIL contention_gnt step=%0d got=%b exp=%b", k, gnt, exp);
      end
      checks++;
      if ($countones(gnt) > 1) begin
        failures++;
        $display("FAIL contention_onehot step=%0d got=%b exp=at_most_one", k, gnt);
      end
      // Winner drops its request for the grant cycle, others keep theirs.
      req = 4'b1111 & ~exp;
    end
    req = '0;
    checks++;
    if (wr_count !== 8'd5) begin
      failures++;
      $display("FAIL contention_wr_count got=%0d exp=5", wr_count);
    end
    raddr = 2'd2;
    #1;
    checks++;
    if (rdata !== 8'hC2) begin
      failures++;
      $display("FAIL contention_rdata got=%h exp=c2", rdata);
    end
    step();
  endtask

  task automatic test_same_addr();
    apply_reset();
    waddr = '0;
    wdata = 32'h33_00_11_00;
    raddr = 2'd0;
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL race_first_gnt got=%b exp=0010", gnt);
    end
    checks++;
    if (rdata !== 8'h11) begin
      failures++;
      $display("FAIL race_first_rdata got=%h exp=11", rdata);
    end
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL race_second_gnt got=%b exp=1000", gnt);
    end
    req = '0;
    checks++;
    if (rdata !== 8'h33) begin
      failures++;
      $display("FAIL race_final_rdata got=%h exp=33", rdata);
    end
    step();
  endtask

  task automatic test_single_hold();
    logic [3:0] exp;
    apply_reset();
    waddr[1:0] = 2'd2;
    wdata[7:0] = 8'h5C;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if (gnt !== exp) begin
        failures++;
        $display("FAIL hold_gnt step=%0d got=%b exp=%b", k, gnt, exp);
      end
    end
    req = '0;
    checks++;
    if (wr_count !== 8'd3) begin
      failures++;
      $display("FAIL hold_wr_count got=%0d exp=3", wr_count);
    end
    step();
  endtask

  task automatic test_wrap();
    int gcnt = 0;
    int cyc  = 0;
    apply_reset();
    waddr[1:0] = 2'd3;
    wdata[7:0] = 8'h9E;
    req = 4'b0001;
    while (gcnt < 256 && cyc < 700) begin
      step();
      cyc++;
      if (gnt[0]) gcnt++;
    end
    checks++;
    if (gcnt != 256) begin
      failures++;
      $display("FAIL wrap_timeout grants=%0d exp=256", gcnt);
    end
    checks++;
    if (wr_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_count_256 got=%0d exp=0", wr_count);
    end
    step();
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_gnt_257 got=%b exp=0001", gnt);
    end
    checks++;
    if (wr_count !== 8'd1) begin
      failures++;
      $display("FAIL wrap_count_257 got=%0d exp=1", wr_count);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    // Make requester 0 the last winner so only a pointer reset favours it again.
    waddr = 8'b00_01_00_00;
    wdata = 32'h00_77_00_FF;
    req = 4'b0001;
    step();
    req = '0;
    step();
    rst = 1'b1;
    req = 4'b0101;
    step();
    raddr = 2'd0;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_gnt got=%b exp=0000", gnt);
    end
    checks++;
    if (rdata !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_rdata got=%h exp=00", rdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_regrant got=%b exp=0001", gnt);
    end
    checks++;
    if (rdata !== 8'hFF) begin
      failures++;
      $display("FAIL rstmid_rdata_after got=%h exp=ff", rdata);
    end
    req = '0;
    step();
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    #2;
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr();
    test_single_hold();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters.
REQ-002 Parameter WIDTH, default 8: data width of each bank register.
REQ-003 Parameter DEPTH, default 4: number of bank registers; ADDR_W = clog2(DEPTH).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 req  input  N_REQ  per-requester write request, level.
REQ-007 waddr  input  N_REQ*ADDR_W  per-requester target register, requester i in slice i.
REQ-008 wdata  input  N_REQ*WIDTH  per-requester write data, requester i in slice i.
REQ-009 gnt  output  N_REQ  registered one-hot grant pulse; marks the accepted write.
REQ-010 raddr  input  ADDR_W  read select.
REQ-011 rdata  output  WIDTH  combinational read of bank[raddr].
REQ-012 wr_count  output  8  registered count of accepted writes; wraps modulo 256.

Function
REQ-013 The block shall own DEPTH enable-gated registers; a register shall hold its value in every cycle it is not written.
REQ-014 Eligible set at edge k: requesters with req=1 and gnt=0 during cycle k.
REQ-015 At each edge with a non-empty eligible set, the block shall select exactly one requester by round-robin, searching upward from (last_winner+1) mod N_REQ.
REQ-016 At the same edge, the block shall write the winner's wdata slice to bank[winner's waddr slice], set gnt to the winner's one-hot, update last_winner, and increment wr_count.
REQ-017 With an empty eligible set, gnt shall be all zeros at the next cycle; bank, last_winner and wr_count shall hold.
REQ-018 gnt shall be high for exactly one cycle per accepted write; at most one gnt bit shall be high at any time.
REQ-019 Latency: a request eligible at edge k shall produce gnt in cycle k+1; rdata shall show the new value from cycle k+1.
REQ-020 Requesters shall hold req, waddr and wdata stable until they see gnt, then may deassert; a req still high in the gnt cycle is excluded (REQ-014); a req still high one cycle later is a new request.
REQ-021 Starvation bound: a continuously asserted req shall be granted within 2*N_REQ cycles.
REQ-022 waddr >= DEPTH (non-power-of-two DEPTH) shall be granted, but no register shall be written.
REQ-023 wr_count shall increment on grants with out-of-range addresses; 255 shall wrap to 0.
REQ-024 Single requester asserting req continuously: gnt every second cycle (REQ-014 exclusion).

Reset
REQ-025 With rst=1 at an edge, the block shall clear all bank registers to 0, gnt to 0 and wr_count to 0, and set last_winner to N_REQ-1 so requester 0 has first priority.
REQ-026 rst shall take precedence over any simultaneous request; no write shall occur and no gnt shall issue for that edge.
REQ-027 Requests pending across a reset are lost; requesters shall re-present them, and arbitration shall restart from requester 0.

Structure
REQ-028 A shared package shall hold the default N_REQ, WIDTH and DEPTH values and the ADDR_W derivation.
REQ-029 Each bank entry shall be one instance of sub-module dff_en_reg: WIDTH-bit, synchronous active-high reset, active-high enable.
REQ-030 The round-robin selection shall be combinational logic inside dff_bank_arbiter; last_winner, gnt and wr_count shall be its only other state.

Verification
REQ-031 Reset: drive rst=1 for 2 cycles with req=4'b1111 -> gnt=0, wr_count=0, and rdata=0 for every raddr.
REQ-032 Single write: req[2]=1, waddr2=1, wdata2=8'hA5 for one edge -> gnt=4'b0100 next cycle; rdata=8'hA5 at raddr=1; wr_count=1.
REQ-033 Contention: all four requesters hold req after reset -> grant order 0,1,2,3,0, with each winner deasserting after gnt; no cycle has two gnt bits set.
REQ-034 Same-address race: requester 1 writes 8'h11 and requester 3 writes 8'h33, both to address 0, asserted together -> requester 1 wins first; final bank[0]=8'h33.
REQ-035 Wrap: perform 256 single writes -> wr_count returns to 0; the 257th write -> wr_count=1.
REQ-036 Reset mid-operation: rst=1 coincides with req[0]=1 and wdata0=8'hFF -> bank unchanged at 0 and gnt=0; after release with req[0] still high -> gnt=4'b0001 next cycle.
